// File: rtl/startup_pkg.sv
// Shared types and parameter helpers for the power-on/restart sequencer.
package startup_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD_RST  = 2'd1,
        HOLD_TS   = 2'd2,
        RUN       = 2'd3
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/startup_seq_if.sv
// Lock/restart inputs and reset/tristate controls of the startup sequencer.
interface startup_seq_if;
    logic       pll_locked;
    logic       restart;
    logic       gsr;
    logic       prld;
    logic       gts;
    logic       ready;
    logic [1:0] state;

    modport master (
        input  pll_locked, restart,
        output gsr, prld, gts, ready, state
    );

    modport slave (
        output pll_locked, restart,
        input  gsr, prld, gts, ready, state
    );
endinterface

// File: rtl/startup_seq_sync2.sv
// Two-flop synchronizer with synchronous active-low clear.
module sync2 (
    input  logic CLK,
    input  logic clr_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge CLK) begin
        if (!clr_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/startup_seq.sv
// Power-on/restart sequencer: qualifies PLL lock, then sequences gsr/prld and gts.
import startup_pkg::*;

module startup_seq #(
    parameter int ROC_CYCLES = 1000,
    parameter int TOC_CYCLES = 0,
    parameter int LOCK_FILT  = 4,
    parameter int CNT_W      = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    startup_seq_if.master bus
);
    if (ROC_CYCLES < 1) begin : g_bad_roc
        $error("ROC_CYCLES must be >= 1");
    end
    if (LOCK_FILT < 1) begin : g_bad_filt
        $error("LOCK_FILT must be >= 1");
    end
    if (TOC_CYCLES < 0) begin : g_bad_toc
        $error("TOC_CYCLES must be >= 0");
    end
    if (max3(ROC_CYCLES, TOC_CYCLES, LOCK_FILT) >= (1 << CNT_W)) begin : g_bad_w
        $error("CNT_W too small for the count parameters");
    end

    localparam int TOC_M1 = (TOC_CYCLES > 0) ? TOC_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(LOCK_FILT);
    localparam logic [CNT_W-1:0] ROC_LAST = CNT_W'(ROC_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOC_LAST = CNT_W'(TOC_M1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic             lk_s;
    logic             lock_ok;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gsr_q, gts_q, rdy_q;

    sync2 u_sync (
        .CLK   (CLK),
        .clr_n (RST_N),
        .d     (bus.pll_locked),
        .q     (lk_s)
    );

    // Qualify on the updated filter value so HOLD_RST starts the same edge it saturates.
    always_comb begin
        filt_d = filt_q;
        if (!lk_s)
            filt_d = '0;
        else if (filt_q != FILT_MAX)
            filt_d = filt_q + ONE;
        lock_ok = (filt_d == FILT_MAX);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!lk_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
        end else if (bus.restart && state_q != WAIT_LOCK) begin
            state_d = HOLD_RST;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    if (lock_ok) begin
                        state_d = HOLD_RST;
                        cnt_d   = '0;
                    end
                end
                HOLD_RST: begin
                    if (cnt_q == ROC_LAST) begin
                        state_d = (TOC_CYCLES > 0) ? HOLD_TS : RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                HOLD_TS: begin
                    if (cnt_q == TOC_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                RUN: begin
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= WAIT_LOCK;
            filt_q  <= '0;
            cnt_q   <= '0;
            gsr_q   <= 1'b1;
            gts_q   <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            gsr_q   <= (state_d == WAIT_LOCK) || (state_d == HOLD_RST);
            gts_q   <= (state_d != RUN);
            rdy_q   <= (state_d == RUN);
        end
    end

    assign bus.gsr   = gsr_q;
    assign bus.prld  = gsr_q;
    assign bus.gts   = gts_q;
    assign bus.ready = rdy_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_startup_seq.sv
// Directed-vector bench for startup_seq (TOC=3 main instance, TOC=0 companion).
module tb_startup_seq;
    typedef struct {
        int         e;
        int         which;
        logic [1:0] st;
        logic       g;
        logic       t;
        logic       r;
    } vec_t;

    typedef struct {
        logic       pll;
        logic       rs;
        logic [1:0] st;
        logic       g;
        logic       t;
        logic       r;
    } gv_t;

    logic CLK;
    logic RST_N;
    int   nvec;
    int   nerr;

    vec_t clean [9];
    gv_t  glitch [10];

    startup_seq_if bus ();
    startup_seq_if bus0 ();

    assign bus0.pll_locked = bus.pll_locked;
    assign bus0.restart    = bus.restart;

    startup_seq #(
        .ROC_CYCLES (8),
        .TOC_CYCLES (3),
        .LOCK_FILT  (4),
        .CNT_W      (16)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    startup_seq #(
        .ROC_CYCLES (8),
        .TOC_CYCLES (0),
        .LOCK_FILT  (4),
        .CNT_W      (16)
    ) dut0 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input int which, input logic [1:0] st,
                       input logic g, input logic t, input logic r);
        logic [5:0] act;
        logic [5:0] exp;
        if (which == 0)
            act = {bus.state, bus.gsr, bus.prld, bus.gts, bus.ready};
        else
            act = {bus0.state, bus0.gsr, bus0.prld, bus0.gts, bus0.ready};
        exp = {st, g, g, t, r};
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s (dut%0d): st/gsr/prld/gts/rdy got %b want %b",
                     nm, which, act, exp);
        end
    endtask

    task automatic run_clean(input string nm);
        int k;
        k = 0;
        bus.pll_locked = 1'b1;
        for (int e = 0; e <= 16; e++) begin
            step();
            while (k < 9 && clean[k].e == e) begin
                chk($sformatf("%s_E%0d", nm, e), clean[k].which, clean[k].st,
                    clean[k].g, clean[k].t, clean[k].r);
                k++;
            end
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        clean[0] = '{0,  0, 2'd0, 1'b1, 1'b1, 1'b0};
        clean[1] = '{4,  0, 2'd0, 1'b1, 1'b1, 1'b0};
        clean[2] = '{5,  0, 2'd1, 1'b1, 1'b1, 1'b0};
        clean[3] = '{12, 0, 2'd1, 1'b1, 1'b1, 1'b0};
        clean[4] = '{12, 1, 2'd1, 1'b1, 1'b1, 1'b0};
        clean[5] = '{13, 0, 2'd2, 1'b0, 1'b1, 1'b0};
        clean[6] = '{13, 1, 2'd3, 1'b0, 1'b0, 1'b1};
        clean[7] = '{15, 0, 2'd2, 1'b0, 1'b1, 1'b0};
        clean[8] = '{16, 0, 2'd3, 1'b0, 1'b0, 1'b1};

        glitch[0] = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        glitch[1] = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        glitch[2] = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        glitch[3] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        glitch[4] = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        glitch[5] = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        glitch[6] = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        glitch[7] = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
        glitch[8] = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        glitch[9] = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0};

        RST_N          = 1'b0;
        bus.pll_locked = 1'b0;
        bus.restart    = 1'b0;
        repeat (3) step();
        chk("reset", 0, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("reset", 1, 2'd0, 1'b1, 1'b1, 1'b0);
        RST_N = 1'b1;

        run_clean("clean");

        step();
        bus.pll_locked = 1'b0;
        step();
        chk("loss_F0", 0, 2'd3, 1'b0, 1'b0, 1'b1);
        step();
        chk("loss_F1", 0, 2'd3, 1'b0, 1'b0, 1'b1);
        step();
        chk("loss_F2", 0, 2'd0, 1'b1, 1'b1, 1'b0);

        run_clean("relock");

        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        chk("rs_run_Er", 0, 2'd1, 1'b1, 1'b1, 1'b0);
        repeat (7) step();
        chk("rs_run_Er7", 0, 2'd1, 1'b1, 1'b1, 1'b0);
        step();
        chk("rs_run_Er8", 0, 2'd2, 1'b0, 1'b1, 1'b0);
        repeat (2) step();
        chk("rs_run_Er10", 0, 2'd2, 1'b0, 1'b1, 1'b0);
        step();
        chk("rs_run_Er11", 0, 2'd3, 1'b0, 1'b0, 1'b1);

        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        repeat (7) step();
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        chk("rs_term", 0, 2'd1, 1'b1, 1'b1, 1'b0);
        repeat (7) step();
        chk("rs_term_7", 0, 2'd1, 1'b1, 1'b1, 1'b0);
        step();
        chk("rs_term_8", 0, 2'd2, 1'b0, 1'b1, 1'b0);

        bus.pll_locked = 1'b0;
        repeat (3) step();
        chk("drop_wait", 0, 2'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.pll_locked = glitch[i].pll;
            bus.restart    = glitch[i].rs;
            step();
            chk($sformatf("glitch_%0d", i), 0, glitch[i].st,
                glitch[i].g, glitch[i].t, glitch[i].r);
        end
        bus.restart = 1'b0;

        repeat (7) step();
        chk("pre_ts", 0, 2'd1, 1'b1, 1'b1, 1'b0);
        step();
        chk("in_ts", 0, 2'd2, 1'b0, 1'b1, 1'b0);
        step();
        RST_N = 1'b0;
        step();
        chk("rst_mid_ts", 0, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("rst_mid_ts", 1, 2'd0, 1'b1, 1'b1, 1'b0);
        RST_N = 1'b1;
        step();
        chk("post_rst", 0, 2'd0, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
